// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a flag register and MUL counter.
// Control outputs are registered from the next-state decode; STR completion pc_wr follows mem_ready.
module multicycle_control #(
    parameter int unsigned ALU_CTRL_W = 3,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_instr_valid,
    input  logic [3:0]            i_cond,
    input  logic [1:0]            i_op,
    input  logic [5:0]            i_funct,
    input  logic [1:0]            i_sh,
    input  logic [3:0]            i_alu_flags,
    input  logic                  i_mem_ready,
    output logic                  o_instr_ready,
    output logic [3:0]            o_flags,
    output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
    output logic                  o_sel_pc,
    output logic                  o_sel_dira,
    output logic                  o_sel_b,
    output logic                  o_sel_wb,
    output logic                  o_sel_dest,
    output logic                  o_reg_wr,
    output logic                  o_mem_wr,
    output logic                  o_mem_rd,
    output logic                  o_pc_wr,
    output logic [1:0]            o_imm_src
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;
    typedef enum logic [2:0] {ClsIllegal, ClsDp, ClsMul, ClsStr, ClsLdr, ClsBranch} class_e;

    localparam logic [3:0] MulLast = 4'(MUL_CYCLES - 1);

    function automatic class_e decode_class(input logic [1:0] op, input logic [5:0] funct,
                                            input logic [1:0] sh);
        class_e cls;
        cls = ClsIllegal;
        case (op)
            2'd0: begin
                if (funct[5:4] != 2'b00) begin
                    if (funct[4:1] inside {4'd2, 4'd4, 4'd12}) begin
                        cls = ClsDp;
                    end else if (funct[4:1] == 4'd13 && !sh[1]) begin
                        cls = ClsDp;
                    end
                end else if (funct[3:1] == 3'b000) begin
                    cls = ClsMul;
                end
            end
            2'd1: begin
                if (funct[2]) begin
                    cls = funct[0] ? ClsLdr : ClsStr;
                end
            end
            2'd2: cls = ClsBranch;
            default: cls = ClsIllegal;
        endcase
        return cls;
    endfunction

    function automatic logic [2:0] dp_alu_code(input logic [5:0] funct, input logic [1:0] sh);
        logic [2:0] code;
        case (funct[4:1])
            4'd2:    code = 3'd1;
            4'd12:   code = 3'd3;
            4'd13:   code = sh[0] ? 3'd5 : 3'd4;
            default: code = 3'd0;
        endcase
        return code;
    endfunction

    // flags bit order: 0 Z, 1 N, 2 C, 3 V
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] fl);
        logic pass;
        case (cond)
            4'd0:    pass = fl[0];
            4'd1:    pass = !fl[0];
            4'd2:    pass = fl[2];
            4'd3:    pass = !fl[2];
            4'd4:    pass = fl[1];
            4'd5:    pass = !fl[1];
            4'd6:    pass = fl[3];
            4'd7:    pass = !fl[3];
            4'd8:    pass = fl[2] && !fl[0];
            4'd9:    pass = !fl[2] || fl[0];
            4'd10:   pass = (fl[1] == fl[3]);
            4'd11:   pass = (fl[1] != fl[3]);
            4'd12:   pass = !fl[0] && (fl[1] == fl[3]);
            4'd13:   pass = fl[0] || (fl[1] != fl[3]);
            4'd14:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    state_e                r_state, w_state_d;
    logic [3:0]            r_cond, w_cond_d;
    logic [1:0]            r_op, w_op_d;
    logic [5:0]            r_funct, w_funct_d;
    logic [1:0]            r_sh, w_sh_d;
    logic [3:0]            r_cnt, w_cnt_d;
    logic [3:0]            r_flags, w_flags_d;
    class_e                w_cls, w_cls_d;
    logic                  w_exec_d;
    logic                  w_str_done;

    logic                  r_instr_ready, w_instr_ready_d;
    logic [ALU_CTRL_W-1:0] r_alu_ctrl, w_alu_ctrl_d;
    logic                  r_sel_pc, w_sel_pc_d;
    logic                  r_sel_dira, w_sel_dira_d;
    logic                  r_sel_b, w_sel_b_d;
    logic                  r_sel_wb, w_sel_wb_d;
    logic                  r_sel_dest, w_sel_dest_d;
    logic                  r_reg_wr, w_reg_wr_d;
    logic                  r_mem_wr, w_mem_wr_d;
    logic                  r_mem_rd, w_mem_rd_d;
    logic                  r_pc_wr, w_pc_wr_d;
    logic [1:0]            r_imm_src, w_imm_src_d;

    assign w_cls = decode_class(r_op, r_funct, r_sh);

    always_comb begin
        w_state_d = r_state;
        w_cond_d  = r_cond;
        w_op_d    = r_op;
        w_funct_d = r_funct;
        w_sh_d    = r_sh;
        w_cnt_d   = r_cnt;
        w_flags_d = r_flags;
        unique case (r_state)
            StFetch: begin
                if (i_instr_valid) begin
                    w_cond_d  = i_cond;
                    w_op_d    = i_op;
                    w_funct_d = i_funct;
                    w_sh_d    = i_sh;
                    w_state_d = StDecode;
                end
            end
            StDecode: begin
                w_cnt_d = 4'd0;
                if (cond_pass(r_cond, r_flags) && w_cls != ClsIllegal) begin
                    w_state_d = StExec;
                end else begin
                    w_state_d = StFetch;
                end
            end
            StExec: begin
                case (w_cls)
                    ClsDp: begin
                        w_state_d = StWb;
                        if (r_funct[0]) begin
                            w_flags_d = i_alu_flags;
                        end
                    end
                    ClsMul: begin
                        if (r_cnt == MulLast) begin
                            w_cnt_d   = 4'd0;
                            w_state_d = StWb;
                            if (r_funct[0]) begin
                                w_flags_d = i_alu_flags;
                            end
                        end else begin
                            w_cnt_d = r_cnt + 4'd1;
                        end
                    end
                    ClsStr, ClsLdr: w_state_d = StMem;
                    default:        w_state_d = StFetch;
                endcase
            end
            StMem: begin
                if (i_mem_ready) begin
                    w_state_d = (w_cls == ClsLdr) ? StWb : StFetch;
                end
            end
            StWb:    w_state_d = StFetch;
            default: w_state_d = StFetch;
        endcase
    end

    assign w_cls_d  = decode_class(w_op_d, w_funct_d, w_sh_d);
    assign w_exec_d = cond_pass(w_cond_d, w_flags_d) && (w_cls_d != ClsIllegal);

    // Output values for the cycle about to start, so they can be registered.
    always_comb begin
        w_instr_ready_d = 1'b0;
        w_alu_ctrl_d    = '0;
        w_sel_pc_d      = 1'b0;
        w_sel_dira_d    = 1'b0;
        w_sel_b_d       = 1'b0;
        w_sel_wb_d      = 1'b0;
        w_sel_dest_d    = 1'b0;
        w_reg_wr_d      = 1'b0;
        w_mem_wr_d      = 1'b0;
        w_mem_rd_d      = 1'b0;
        w_pc_wr_d       = 1'b0;
        w_imm_src_d     = 2'd0;
        unique case (w_state_d)
            StFetch:  w_instr_ready_d = 1'b1;
            StDecode: w_pc_wr_d = !w_exec_d;
            StExec: begin
                case (w_cls_d)
                    ClsDp: begin
                        w_alu_ctrl_d = ALU_CTRL_W'(dp_alu_code(w_funct_d, w_sh_d));
                        w_sel_b_d    = w_funct_d[5];
                        w_sel_dira_d = 1'b1;
                        w_sel_dest_d = 1'b1;
                    end
                    ClsMul: w_alu_ctrl_d = ALU_CTRL_W'(3'd2);
                    ClsStr, ClsLdr: begin
                        w_sel_b_d   = w_funct_d[5];
                        w_imm_src_d = 2'd1;
                    end
                    ClsBranch: begin
                        w_imm_src_d = 2'd2;
                        w_sel_pc_d  = 1'b1;
                        w_pc_wr_d   = 1'b1;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                w_mem_wr_d = (w_cls_d == ClsStr);
                w_mem_rd_d = (w_cls_d == ClsLdr);
            end
            StWb: begin
                w_reg_wr_d   = 1'b1;
                w_sel_dest_d = 1'b1;
                w_pc_wr_d    = 1'b1;
                w_sel_wb_d   = (w_cls_d == ClsLdr);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StFetch;
            r_cond        <= 4'd0;
            r_op          <= 2'd0;
            r_funct       <= 6'd0;
            r_sh          <= 2'd0;
            r_cnt         <= 4'd0;
            r_flags       <= 4'd0;
            r_instr_ready <= 1'b1;
            r_alu_ctrl    <= '0;
            r_sel_pc      <= 1'b0;
            r_sel_dira    <= 1'b0;
            r_sel_b       <= 1'b0;
            r_sel_wb      <= 1'b0;
            r_sel_dest    <= 1'b0;
            r_reg_wr      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_pc_wr       <= 1'b0;
            r_imm_src     <= 2'd0;
        end else begin
            r_state       <= w_state_d;
            r_cond        <= w_cond_d;
            r_op          <= w_op_d;
            r_funct       <= w_funct_d;
            r_sh          <= w_sh_d;
            r_cnt         <= w_cnt_d;
            r_flags       <= w_flags_d;
            r_instr_ready <= w_instr_ready_d;
            r_alu_ctrl    <= w_alu_ctrl_d;
            r_sel_pc      <= w_sel_pc_d;
            r_sel_dira    <= w_sel_dira_d;
            r_sel_b       <= w_sel_b_d;
            r_sel_wb      <= w_sel_wb_d;
            r_sel_dest    <= w_sel_dest_d;
            r_reg_wr      <= w_reg_wr_d;
            r_mem_wr      <= w_mem_wr_d;
            r_mem_rd      <= w_mem_rd_d;
            r_pc_wr       <= w_pc_wr_d;
            r_imm_src     <= w_imm_src_d;
        end
    end

    // A store retires in the very cycle memory accepts it.
    assign w_str_done = (r_state == StMem) && (w_cls == ClsStr) && i_mem_ready;

    assign o_instr_ready = r_instr_ready;
    assign o_flags       = r_flags;
    assign o_alu_ctrl    = r_alu_ctrl;
    assign o_sel_pc      = r_sel_pc;
    assign o_sel_dira    = r_sel_dira;
    assign o_sel_b       = r_sel_b;
    assign o_sel_wb      = r_sel_wb;
    assign o_sel_dest    = r_sel_dest;
    assign o_reg_wr      = r_reg_wr;
    assign o_mem_wr      = r_mem_wr;
    assign o_mem_rd      = r_mem_rd;
    assign o_pc_wr       = r_pc_wr | w_str_done;
    assign o_imm_src     = r_imm_src;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction table, reset corner cases, and a
// randomized instruction stream checked cycle by cycle against a per-instruction trace model.
module tb_multicycle_control;

    localparam int MULC = 4;
    localparam int K_ILL = 0, K_DP = 1, K_MUL = 2, K_STR = 3, K_LDR = 4, K_BR = 5;

    logic       clk;
    logic       rst_n;
    logic       i_instr_valid;
    logic [3:0] i_cond;
    logic [1:0] i_op;
    logic [5:0] i_funct;
    logic [1:0] i_sh;
    logic [3:0] i_alu_flags;
    logic       i_mem_ready;
    logic       o_instr_ready;
    logic [3:0] o_flags;
    logic [2:0] o_alu_ctrl;
    logic       o_sel_pc, o_sel_dira, o_sel_b, o_sel_wb, o_sel_dest;
    logic       o_reg_wr, o_mem_wr, o_mem_rd, o_pc_wr;
    logic [1:0] o_imm_src;

    int n_cmp = 0;
    int n_fail = 0;

    multicycle_control #(
        .ALU_CTRL_W(3),
        .MUL_CYCLES(MULC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_instr_valid(i_instr_valid),
        .i_cond       (i_cond),
        .i_op         (i_op),
        .i_funct      (i_funct),
        .i_sh         (i_sh),
        .i_alu_flags  (i_alu_flags),
        .i_mem_ready  (i_mem_ready),
        .o_instr_ready(o_instr_ready),
        .o_flags      (o_flags),
        .o_alu_ctrl   (o_alu_ctrl),
        .o_sel_pc     (o_sel_pc),
        .o_sel_dira   (o_sel_dira),
        .o_sel_b      (o_sel_b),
        .o_sel_wb     (o_sel_wb),
        .o_sel_dest   (o_sel_dest),
        .o_reg_wr     (o_reg_wr),
        .o_mem_wr     (o_mem_wr),
        .o_mem_rd     (o_mem_rd),
        .o_pc_wr      (o_pc_wr),
        .o_imm_src    (o_imm_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [1:0] sh;
        logic [3:0] af;
        int         wt;
        int         cyc;
        logic [3:0] fl;
        int         nreg;
        int         nmw;
        int         nmr;
        int         npc;
        int         nmul;
    } vec_t;

    typedef struct {
        logic [18:0] exp;
        logic [3:0]  af;
        logic        mr;
    } cyc_t;

    cyc_t       q[$];
    logic [3:0] m_flags;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] ev(input logic [3:0] fl, input logic rdy, input logic [2:0] alu,
                                       input logic spc, input logic dira, input logic sb,
                                       input logic swb, input logic sdest, input logic rw,
                                       input logic mw, input logic mr, input logic pcw,
                                       input logic [1:0] imm);
        return {rdy, fl, alu, spc, dira, sb, swb, sdest, rw, mw, mr, pcw, imm};
    endfunction

    function automatic logic [18:0] pack_dut();
        return {o_instr_ready, o_flags, o_alu_ctrl, o_sel_pc, o_sel_dira, o_sel_b, o_sel_wb,
                o_sel_dest, o_reg_wr, o_mem_wr, o_mem_rd, o_pc_wr, o_imm_src};
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit z, n, cy, v;
        z = f[0]; n = f[1]; cy = f[2]; v = f[3];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expand one instruction into its expected per-cycle trace, starting at the accepting FETCH.
    task automatic build(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                         input logic [1:0] sh, input int wt);
        int kind, n;
        logic [2:0] alu;
        logic [3:0] nf;
        bit ok;
        cyc_t r;
        kind = K_ILL;
        alu = 3'd0;
        if (op == 2'd0 && f[5:4] != 2'b00) begin
            case (f[4:1])
                4'd2:  begin kind = K_DP; alu = 3'd1; end
                4'd4:  begin kind = K_DP; alu = 3'd0; end
                4'd12: begin kind = K_DP; alu = 3'd3; end
                4'd13: begin
                    if (sh == 2'd0) begin kind = K_DP; alu = 3'd4; end
                    else if (sh == 2'd1) begin kind = K_DP; alu = 3'd5; end
                end
                default: ;
            endcase
        end else if (op == 2'd0 && f[3:1] == 3'b000) begin
            kind = K_MUL;
        end else if (op == 2'd1 && f[2]) begin
            kind = f[0] ? K_LDR : K_STR;
        end else if (op == 2'd2) begin
            kind = K_BR;
        end
        ok = (kind != K_ILL) && cond_ok(c, m_flags);
        r.af = 4'($urandom); r.mr = 1'($urandom);
        r.exp = ev(m_flags, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        q.push_back(r);
        r.af = 4'($urandom); r.mr = 1'($urandom);
        r.exp = ev(m_flags, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, !ok, 0);
        q.push_back(r);
        if (!ok) return;
        n = (kind == K_MUL) ? MULC : 1;
        nf = m_flags;
        for (int i = 0; i < n; i++) begin
            r.af = 4'($urandom); r.mr = 1'($urandom);
            case (kind)
                K_DP:  r.exp = ev(m_flags, 0, alu, 0, 1, f[5], 0, 1, 0, 0, 0, 0, 0);
                K_MUL: r.exp = ev(m_flags, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                K_BR:  r.exp = ev(m_flags, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2);
                default: r.exp = ev(m_flags, 0, 0, 0, 0, f[5], 0, 0, 0, 0, 0, 0, 1);
            endcase
            if (i == n - 1 && (kind == K_DP || kind == K_MUL) && f[0]) nf = r.af;
            q.push_back(r);
        end
        m_flags = nf;
        if (kind == K_BR) return;
        if (kind == K_STR || kind == K_LDR) begin
            for (int i = 0; i <= wt; i++) begin
                r.af = 4'($urandom);
                r.mr = (i == wt);
                r.exp = ev(m_flags, 0, 0, 0, 0, 0, 0, 0, 0, kind == K_STR, kind == K_LDR,
                           kind == K_STR && i == wt, 0);
                q.push_back(r);
            end
            if (kind == K_STR) return;
        end
        r.af = 4'($urandom); r.mr = 1'($urandom);
        r.exp = ev(m_flags, 0, 0, 0, 0, 0, kind == K_LDR, 1, 1, 0, 0, 1, 0);
        q.push_back(r);
    endtask

    task automatic run_entry(input int idx, input vec_t v);
        int cyc, nreg, nmw, nmr, npc, nmul, mc;
        bit done;
        cyc = 0; nreg = 0; nmw = 0; nmr = 0; npc = 0; nmul = 0; mc = 0; done = 0;
        i_instr_valid = 1'b1;
        i_cond = v.cond; i_op = v.op; i_funct = v.funct; i_sh = v.sh;
        i_alu_flags = v.af;
        for (int k = 0; k < 64 && !done; k++) begin
            if (o_mem_wr || o_mem_rd) begin
                i_mem_ready = (mc == v.wt);
                mc++;
            end else begin
                i_mem_ready = 1'b0;
            end
            #1;
            if (k > 0 && o_instr_ready) begin
                done = 1;
            end else begin
                cyc++;
                nreg += int'(o_reg_wr);
                nmw  += int'(o_mem_wr);
                nmr  += int'(o_mem_rd);
                npc  += int'(o_pc_wr);
                nmul += int'(o_alu_ctrl == 3'd2);
                @(negedge clk);
            end
        end
        if (!done) check($sformatf("tbl%0d_timeout", idx), 0, 1);
        check($sformatf("tbl%0d_cycles", idx), cyc, v.cyc);
        check($sformatf("tbl%0d_flags", idx), o_flags, v.fl);
        check($sformatf("tbl%0d_reg_mw_mr_pc", idx), {8'(nreg), 8'(nmw), 8'(nmr), 8'(npc)},
              {8'(v.nreg), 8'(v.nmw), 8'(v.nmr), 8'(v.npc)});
        check($sformatf("tbl%0d_mul_cycles", idx), nmul, v.nmul);
    endtask

    task automatic apply_q(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                           input logic [1:0] sh);
        cyc_t r;
        i_instr_valid = 1'b1;
        i_cond = c; i_op = op; i_funct = f; i_sh = sh;
        while (q.size() > 0) begin
            r = q.pop_front();
            i_alu_flags = r.af;
            i_mem_ready = r.mr;
            #1;
            check("rand_cycle", pack_dut(), r.exp);
            @(negedge clk);
        end
    endtask

    vec_t tbl[14];

    initial begin
        logic [3:0] c;
        logic [1:0] op, sh;
        logic [5:0] f;
        logic [3:0] code;
        int wt, idle;

        tbl[0]  = '{4'd14, 2'd0, 6'b101001, 2'd0, 4'b0001, 0, 4, 4'b0001, 1, 0, 0, 1, 0};
        tbl[1]  = '{4'd1,  2'd2, 6'b000000, 2'd0, 4'b1111, 0, 2, 4'b0001, 0, 0, 0, 1, 0};
        tbl[2]  = '{4'd0,  2'd2, 6'b000000, 2'd0, 4'b1111, 0, 3, 4'b0001, 0, 0, 0, 1, 0};
        tbl[3]  = '{4'd14, 2'd0, 6'b000000, 2'd0, 4'b1111, 0, 7, 4'b0001, 1, 0, 0, 1, 4};
        tbl[4]  = '{4'd14, 2'd0, 6'b000001, 2'd0, 4'b0110, 0, 7, 4'b0110, 1, 0, 0, 1, 4};
        tbl[5]  = '{4'd14, 2'd1, 6'b100101, 2'd0, 4'b1111, 3, 8, 4'b0110, 1, 0, 4, 1, 0};
        tbl[6]  = '{4'd14, 2'd1, 6'b100100, 2'd0, 4'b1111, 2, 6, 4'b0110, 0, 3, 0, 1, 0};
        tbl[7]  = '{4'd15, 2'd0, 6'b101001, 2'd0, 4'b1111, 0, 2, 4'b0110, 0, 0, 0, 1, 0};
        tbl[8]  = '{4'd14, 2'd3, 6'b101001, 2'd0, 4'b1111, 0, 2, 4'b0110, 0, 0, 0, 1, 0};
        tbl[9]  = '{4'd14, 2'd0, 6'b111010, 2'd2, 4'b1111, 0, 2, 4'b0110, 0, 0, 0, 1, 0};
        tbl[10] = '{4'd14, 2'd0, 6'b111011, 2'd1, 4'b1000, 0, 4, 4'b1000, 1, 0, 0, 1, 0};
        tbl[11] = '{4'd12, 2'd0, 6'b100101, 2'd0, 4'b0000, 0, 2, 4'b1000, 0, 0, 0, 1, 0};
        tbl[12] = '{4'd11, 2'd0, 6'b100101, 2'd0, 4'b0010, 0, 4, 4'b0010, 1, 0, 0, 1, 0};
        tbl[13] = '{4'd14, 2'd1, 6'b100001, 2'd0, 4'b1111, 0, 2, 4'b0010, 0, 0, 0, 1, 0};

        rst_n = 1'b1;
        i_instr_valid = 1'b0; i_cond = 4'd0; i_op = 2'd0; i_funct = 6'd0; i_sh = 2'd0;
        i_alu_flags = 4'd0; i_mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("reset_outputs", pack_dut(), ev(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("reset_release", pack_dut(), ev(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);

        foreach (tbl[i]) run_entry(i, tbl[i]);

        // Store stalled in MEM, then asynchronous reset.
        i_instr_valid = 1'b1; i_cond = 4'd14; i_op = 2'd1; i_funct = 6'b000100; i_sh = 2'd0;
        i_mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("str_mem_wr_held", {o_mem_wr, o_flags}, {1'b1, 4'b0010});
        #1 rst_n = 1'b0;
        #1 check("rst_mid_mem", pack_dut(), ev(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        i_cond = 4'd15; i_op = 2'd0; i_funct = 6'b101001;
        @(posedge clk);
        #1 check("rst_held_edge", pack_dut(), ev(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("rst_release_2", pack_dut(), ev(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1 check("first_accept", pack_dut(), ev(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        @(negedge clk);
        i_instr_valid = 1'b0;
        #1 check("skip_back_fetch", pack_dut(), ev(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);

        m_flags = 4'd0;
        for (int n = 0; n < 200; n++) begin
            c = ($urandom_range(0, 2) != 0) ? 4'd14 : 4'($urandom);
            op = 2'($urandom_range(0, 3));
            sh = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            f = 6'($urandom);
            if (op == 2'd0 && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: code = 4'd2;
                    1: code = 4'd4;
                    2: code = 4'd12;
                    default: code = 4'd13;
                endcase
                f = {(code < 4'd12) ? 1'b1 : 1'($urandom), code, 1'($urandom)};
                if ($urandom_range(0, 4) == 0) f = {5'b00000, 1'($urandom)};
            end else if (op == 2'd1 && $urandom_range(0, 3) != 0) begin
                f[2] = 1'b1;
            end
            wt = $urandom_range(0, 3);
            build(c, op, f, sh, wt);
            apply_q(c, op, f, sh);
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                i_instr_valid = 1'b0;
                i_alu_flags = 4'($urandom);
                i_mem_ready = 1'($urandom);
                #1 check("idle_fetch", pack_dut(), ev(m_flags, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
